// File: rtl/axis_capture_sequencer_if.sv
// AXI4-Stream bundle used by axis_capture_sequencer for both the source and DMA sides.
interface axis_capture_sequencer_if #(
    parameter int DATA_W = 32
) ();
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/axis_capture_sequencer.sv
// Gates a free-running stream into counted, DMA-armed packets with internal TLAST.
// Optional: define CAPTURE_DROP_CNT_EN for a saturating count of discarded words.
module axis_capture_sequencer #(
    parameter int DATA_W   = 32,
    parameter int WCNT_W   = 24,
    parameter int PCNT_W   = 16,
    parameter int CRED_MAX = 15
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [WCNT_W-1:0]           cfg_words_per_pkt,
    input  logic [PCNT_W-1:0]           cfg_num_pkts,
    input  logic                        dma_arm,
    axis_capture_sequencer_if.slave     s_axis,
    axis_capture_sequencer_if.master    m_axis,
    output logic                        busy,
    output logic                        done_irq,
    output logic [PCNT_W-1:0]           pkt_count,
    output logic [31:0]                 drop_count
);
    localparam int CW = $clog2(CRED_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_ARM, STREAM, DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   r_wpp_m1;
    logic [PCNT_W-1:0]   r_npkts;
    logic [PCNT_W-1:0]   r_pkt_count;
    logic [CW-1:0]       r_cred;
    logic                r_abort_pend;

    logic                w_stream;
    logic                w_last;
    logic                w_hs;
    logic                w_last_hs;
    logic                w_arm_ok;
    logic                w_cred_inc;
    logic                w_run_end;
    logic                w_start_ok;
    logic [PCNT_W-1:0]   w_pkt_inc;
    logic [DATA_W-1:0]   w_data;

    assign w_stream   = (r_state == STREAM);
    assign w_start_ok = (r_state == IDLE) && start;
    assign w_last     = (r_wcnt == r_wpp_m1);
    assign w_hs       = w_stream && s_axis.tvalid && m_axis.tready;
    assign w_last_hs  = w_hs && w_last;
    assign w_arm_ok   = (r_state == WAIT_ARM) && !abort && ((r_cred != '0) || dma_arm);
    assign w_cred_inc = dma_arm && (r_state != IDLE);
    assign w_pkt_inc  = r_pkt_count + PCNT_W'(1);
    assign w_run_end  = (r_npkts != '0) && (w_pkt_inc == r_npkts);
    assign w_data     = s_axis.tdata;

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx     = r_state;
        m_axis.tvalid  = 1'b0;
        m_axis.tlast   = 1'b0;
        m_axis.tdata   = w_data;
        s_axis.tready  = 1'b1;
        busy           = (r_state != IDLE);
        done_irq       = 1'b0;
        case (r_state)
            IDLE:     if (start) w_state_nx = WAIT_ARM;
            WAIT_ARM: begin
                if (abort)         w_state_nx = DONE;
                else if (w_arm_ok) w_state_nx = STREAM;
            end
            STREAM: begin
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tlast  = w_last;
                s_axis.tready = m_axis.tready;
                // A pending abort is only acted on at a packet boundary.
                if (w_last_hs) w_state_nx = (r_abort_pend || abort || w_run_end) ? DONE : WAIT_ARM;
            end
            DONE: begin
                done_irq   = 1'b1;
                w_state_nx = IDLE;
            end
            default:  w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wcnt       <= '0;
            r_wpp_m1     <= '0;
            r_npkts      <= '0;
            r_pkt_count  <= '0;
            r_cred       <= '0;
            r_abort_pend <= 1'b0;
        end else if (w_start_ok) begin
            r_wcnt       <= '0;
            r_wpp_m1     <= (cfg_words_per_pkt == '0) ? '0 : cfg_words_per_pkt - WCNT_W'(1);
            r_npkts      <= cfg_num_pkts;
            r_pkt_count  <= '0;
            r_cred       <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            if (w_arm_ok)  r_wcnt <= '0;
            else if (w_hs) r_wcnt <= r_wcnt + WCNT_W'(1);

            if (w_last_hs) r_pkt_count <= w_pkt_inc;

            if (r_state == DONE)          r_abort_pend <= 1'b0;
            else if (w_stream && abort)   r_abort_pend <= 1'b1;

            // Arm and consume in the same cycle cancel out, even when saturated.
            if (w_cred_inc && !w_arm_ok) begin
                if (r_cred != CW'(CRED_MAX)) r_cred <= r_cred + CW'(1);
            end else if (!w_cred_inc && w_arm_ok) begin
                r_cred <= r_cred - CW'(1);
            end
        end
    end

    assign pkt_count = r_pkt_count;

`ifdef CAPTURE_DROP_CNT_EN
    logic [31:0] r_drop;

    always_ff @(posedge aclk) begin
        if (!aresetn || w_start_ok)                       r_drop <= '0;
        else if (!w_stream && s_axis.tvalid && r_drop != '1) r_drop <= r_drop + 32'd1;
    end

    assign drop_count = r_drop;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_capture_sequencer.sv
// Directed bench for axis_capture_sequencer: packetisation, arming, stalls, abort, credits, reset.
module tb_axis_capture_sequencer;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [23:0] cfg_words_per_pkt;
    logic [15:0] cfg_num_pkts;
    logic        dma_arm;
    logic        busy;
    logic        done_irq;
    logic [15:0] pkt_count;
    logic [31:0] drop_count;

    int          tests = 0;
    int          fails = 0;

    int          out_words;
    int          tlast_cnt;
    int          done_cnt;
    int          seq_err;
    int          pkt_word;
    logic [63:0] tlast_mask;
    logic [31:0] last_data;
    logic [31:0] exp_drop;

    axis_capture_sequencer_if #(.DATA_W(32)) s_axis ();
    axis_capture_sequencer_if #(.DATA_W(32)) m_axis ();

    axis_capture_sequencer #(
        .DATA_W   (32),
        .WCNT_W   (24),
        .PCNT_W   (16),
        .CRED_MAX (15)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .start             (start),
        .abort             (abort),
        .cfg_words_per_pkt (cfg_words_per_pkt),
        .cfg_num_pkts      (cfg_num_pkts),
        .dma_arm           (dma_arm),
        .s_axis            (s_axis),
        .m_axis            (m_axis),
        .busy              (busy),
        .done_irq          (done_irq),
        .pkt_count         (pkt_count),
        .drop_count        (drop_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        out_words  = 0;
        tlast_cnt  = 0;
        done_cnt   = 0;
        seq_err    = 0;
        pkt_word   = 0;
        tlast_mask = '0;
    endtask

    // One clock: monitor outputs before the edge, advance the source on its handshake, drop pulses.
    task automatic tick();
        logic s_hs;
        #1;
        s_hs = s_axis.tvalid && s_axis.tready;
        if (m_axis.tvalid && m_axis.tready) begin
            if (pkt_word != 0 && m_axis.tdata != last_data + 32'd1) seq_err++;
            last_data = m_axis.tdata;
            if (m_axis.tlast) begin
                if (out_words < 64) tlast_mask[out_words] = 1'b1;
                tlast_cnt++;
                pkt_word = 0;
            end else begin
                pkt_word++;
            end
            out_words++;
        end
        if (done_irq) done_cnt++;
        @(posedge aclk);
        #1;
        if (s_hs) s_axis.tdata = s_axis.tdata + 32'd1;
        start   = 1'b0;
        abort   = 1'b0;
        dma_arm = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idle_err;
        int   stall_err;
        bit   held;
        bit   abort_sent;
        logic [31:0] d0;
        logic        l0;

        aresetn           = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        dma_arm           = 1'b0;
        cfg_words_per_pkt = 24'd4;
        cfg_num_pkts      = 16'd2;
        s_axis.tvalid     = 1'b1;
        s_axis.tdata      = 32'h1000;
        s_axis.tlast      = 1'b0;
        m_axis.tready     = 1'b1;
        clr_mon();
        tick();
        tick();
        #1;
        check("rst_busy",   busy, 0);
        check("rst_done",   done_irq, 0);
        check("rst_pkt",    pkt_count, 0);
        check("rst_drop",   drop_count, 0);
        check("rst_mvalid", m_axis.tvalid, 0);
        check("rst_mlast",  m_axis.tlast, 0);
        check("rst_sready", s_axis.tready, 1);
        aresetn = 1'b1;
        tick();

        // Basic run: 2 packets of 4 words.
        clr_mon();
        start = 1'b1;
        tick();
        check("s1_busy", busy, 1);
        dma_arm = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        run_to_done(60);
        check("s1_words", out_words, 8);
        check("s1_tlast", tlast_mask, 64'h88);
        check("s1_pkt",   pkt_count, 2);
        check("s1_done",  done_cnt, 1);
        check("s1_seq",   seq_err, 0);
        check("s1_idle",  busy, 0);

        // Arm withheld for 20 cycles: everything is dropped, nothing leaks out.
        clr_mon();
        start = 1'b1;
        tick();
        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_axis.tvalid !== 1'b0 || s_axis.tready !== 1'b1) idle_err++;
            tick();
        end
        check("s2_idle_out", idle_err, 0);
        check("s2_nowords",  out_words, 0);
`ifdef CAPTURE_DROP_CNT_EN
        exp_drop = 32'd20;
`else
        exp_drop = 32'd0;
`endif
        check("s2_drop", drop_count, exp_drop);
        dma_arm = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        run_to_done(60);
        check("s2_words", out_words, 8);
        check("s2_tlast", tlast_mask, 64'h88);
        check("s2_seq",   seq_err, 0);

        // DMA back-pressure alternating every cycle: stalled beat must hold.
        clr_mon();
        cfg_num_pkts = 16'd1;
        start = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        stall_err = 0;
        held      = 1'b0;
        d0        = '0;
        l0        = 1'b0;
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            m_axis.tready = (i % 2 == 1);
            #1;
            if (!m_axis.tready && m_axis.tvalid) begin
                d0   = m_axis.tdata;
                l0   = m_axis.tlast;
                held = 1'b1;
            end else if (held) begin
                if (m_axis.tdata !== d0 || m_axis.tlast !== l0) stall_err++;
                held = 1'b0;
            end
            tick();
        end
        m_axis.tready = 1'b1;
        check("s3_stall", stall_err, 0);
        check("s3_words", out_words, 4);
        check("s3_tlast", tlast_mask, 64'h8);
        check("s3_done",  done_cnt, 1);

        // Continuous mode, abort on word 2 of packet 3: packet 3 still completes.
        clr_mon();
        cfg_num_pkts = 16'd0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            dma_arm = 1'b1;
            tick();
        end
        abort_sent = 1'b0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            if (!abort_sent && m_axis.tvalid && out_words == 9) begin
                abort      = 1'b1;
                abort_sent = 1'b1;
            end
            tick();
        end
        check("s4_words", out_words, 12);
        check("s4_tlast", tlast_mask, 64'h888);
        check("s4_pkt",   pkt_count, 3);
        check("s4_done",  done_cnt, 1);
        check("s4_idle",  busy, 0);

        // 20 arms while stalled: one consumed, credits cap at 15.
        clr_mon();
        m_axis.tready = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            dma_arm = 1'b1;
            tick();
        end
        m_axis.tready = 1'b1;
        for (int i = 0; i < 120; i++) tick();
        check("s5_words",  out_words, 64);
        check("s5_tlasts", tlast_cnt, 16);
        check("s5_pkt",    pkt_count, 16);
        check("s5_busy",   busy, 1);
        check("s5_mvalid", m_axis.tvalid, 0);
        abort = 1'b1;
        tick();
        tick();
        check("s5_done", done_cnt, 1);
        check("s5_idle", busy, 0);

        // Reset mid-packet, then a clean run with words_per_pkt=0 (treated as 1).
        clr_mon();
        cfg_num_pkts = 16'd0;
        start = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        tick();
        tick();
        check("s6_midpkt", out_words, 2);
        aresetn = 1'b0;
        tick();
        check("s6_busy",   busy, 0);
        check("s6_mvalid", m_axis.tvalid, 0);
        check("s6_mlast",  m_axis.tlast, 0);
        check("s6_sready", s_axis.tready, 1);
        check("s6_pkt",    pkt_count, 0);
        check("s6_drop",   drop_count, 0);
        check("s6_doneo",  done_irq, 0);
        aresetn = 1'b1;
        tick();
        clr_mon();
        cfg_words_per_pkt = 24'd0;
        cfg_num_pkts      = 16'd2;
        start = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        dma_arm = 1'b1;
        tick();
        run_to_done(40);
        check("s6_words", out_words, 2);
        check("s6_tlast", tlast_mask, 64'h3);
        check("s6_pkt2",  pkt_count, 2);
        check("s6_done",  done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
